sa_port_arbiter: RTL and testbench

- Output-port switch allocator for the 5-port packet router (ports L, N, E, S, W).
- One instance per output port. It arbitrates, round-robin, among the five route-computed inputs requesting this port.
- It tracks credits for the downstream FIFO and locks the port for the duration of multi-flit packets.
- It drives the registered output flit, valid, one-hot arbitration result and the FIFO write strobe.

---
 rtl/router_pkg.sv | 38 +++
 rtl/rr_pick.sv | 22 ++
 rtl/sa_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_sa_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, flit type codes, port indices
// and the per-output-port allocator state encoding.
package router_pkg;

    localparam int FLIT_W   = 40;
    localparam int NPORT    = 5;
    localparam int NCREDITS = 4;

    localparam int SRC_LSB  = 36;
    localparam int SRC_W    = 4;
    localparam int DST_LSB  = 32;
    localparam int DST_W    = 4;
    localparam int TS_LSB   = 24;
    localparam int TS_W     = 8;
    localparam int DATA_LSB = 2;
    localparam int DATA_W   = 22;
    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;

    localparam int P_L = 0;
    localparam int P_N = 1;
    localparam int P_E = 2;
    localparam int P_S = 3;
    localparam int P_W = 4;

    typedef enum logic [1:0] {
        SINGLE = 2'b00,
        HEAD   = 2'b01,
        BODY   = 2'b10,
        TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sa_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: first set request at or above ptr_i,
// wrapping, found via a doubled request vector.
module rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    localparam logic [2*N-1:0] ONE = 1;

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] msk;
    logic [2*N-1:0] low;

    assign dbl   = {req_i, req_i};
    assign msk   = dbl & ~((ONE << ptr_i) - ONE);
    assign low   = msk & (~msk + ONE);
    assign gnt_o = low[N-1:0] | low[2*N-1:N];

endmodule

// File: rtl/sa_port_arbiter.sv
// Output-port switch allocator: round-robin grant, credit tracking and
// packet locking for one output port of the 5-port router.
module sa_port_arbiter
    import router_pkg::*;
#(
    parameter int DATASIZE = FLIT_W,
    parameter int NREQ     = NPORT,
    parameter int CREDITS  = NCREDITS,
    parameter int CW       = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic                     full_in,
    input  logic                     credit_ret,
    output logic [NREQ-1:0]          grant,
    output logic [DATASIZE-1:0]      data_out,
    output logic                     valid_out,
    output logic                     outfifo_winc,
    output logic [NREQ-1:0]          arb_res,
    output logic [CW-1:0]            credits,
    output logic                     locked,
    output logic                     proto_err
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = 1;

    sa_state_e           state_q, state_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       own_q, own_d;
    logic [CW-1:0]       cred_q, cred_d;
    logic [DATASIZE-1:0] dout_q;
    logic [NREQ-1:0]     arb_q;
    logic                vld_q;
    logic                err_q, err_d;

    logic [NREQ-1:0]     pick;
    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       win;
    logic [DATASIZE-1:0] wflit;
    flit_type_e          wtype;
    logic                en;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    rr_pick #(.N(NREQ)) u_pick (
        .req_i (req),
        .ptr_i (rr_q),
        .gnt_o (pick)
    );

    always_comb begin
        en      = !full_in && (cred_q != '0);
        gnt     = '0;
        win     = '0;
        wflit   = '0;
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        err_d   = err_q;
        cred_d  = cred_q;

        unique case (state_q)
            IDLE:   gnt = en ? pick : '0;
            LOCKED: gnt = (en && req[own_q]) ? (ONE << own_q) : '0;
        endcase

        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win   = IW'(i);
                wflit = req_data[i*DATASIZE +: DATASIZE];
            end
        end
        wtype = flit_type_e'(wflit[TYPE_LSB +: TYPE_W]);

        if (|gnt) begin
            unique case (state_q)
                IDLE: begin
                    unique case (wtype)
                        HEAD: begin
                            state_d = LOCKED;
                            own_d   = win;
                        end
                        SINGLE: rr_d = inc(win);
                        BODY, TAIL: begin
                            err_d = 1'b1;
                            rr_d  = inc(win);
                        end
                    endcase
                end
                LOCKED: begin
                    unique case (wtype)
                        TAIL: begin
                            state_d = IDLE;
                            rr_d    = inc(own_q);
                        end
                        BODY: ;
                        HEAD: err_d = 1'b1;
                        SINGLE: begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            rr_d    = inc(own_q);
                        end
                    endcase
                end
            endcase
        end

        // A return into a full counter is a downstream bookkeeping error.
        if (|gnt && !credit_ret) begin
            cred_d = cred_q - 1'b1;
        end else if (!(|gnt) && credit_ret) begin
            if (cred_q == CW'(CREDITS)) err_d = 1'b1;
            else                        cred_d = cred_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            own_q   <= '0;
            cred_q  <= CW'(CREDITS);
            dout_q  <= '0;
            vld_q   <= 1'b0;
            arb_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            cred_q  <= cred_d;
            vld_q   <= |gnt;
            arb_q   <= gnt;
            err_q   <= err_d;
            if (|gnt) dout_q <= wflit;
        end
    end

    assign grant        = gnt;
    assign data_out     = dout_q;
    assign valid_out    = vld_q;
    assign outfifo_winc = vld_q;
    assign arb_res      = arb_q;
    assign credits      = cred_q;
    assign locked       = (state_q == LOCKED);
    assign proto_err    = err_q;

endmodule

// File: tb/tb_sa_port_arbiter.sv
// Directed vector bench for the output-port switch allocator.
module tb_sa_port_arbiter;

    localparam int DS = 40;
    localparam int NR = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*DS-1:0] req_data;
    logic             full_in;
    logic             credit_ret;
    logic [NR-1:0]    grant;
    logic [DS-1:0]    data_out;
    logic             valid_out;
    logic             outfifo_winc;
    logic [NR-1:0]    arb_res;
    logic [2:0]       credits;
    logic             locked;
    logic             proto_err;

    sa_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .full_in      (full_in),
        .credit_ret   (credit_ret),
        .grant        (grant),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .outfifo_winc (outfifo_winc),
        .arb_res      (arb_res),
        .credits      (credits),
        .locked       (locked),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [9:0] typ;
        logic       full;
        logic       cret;
        logic [4:0] eg;
        logic       elk;
        int         ec;
        logic       ee;
    } vec_t;

    localparam logic [9:0] AS = 10'h000;
    localparam logic [9:0] EH = 10'h010;
    localparam logic [9:0] EB = 10'h020;
    localparam logic [9:0] ET = 10'h030;

    vec_t          tv[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [DS-1:0] exp_d;

    function automatic vec_t mk(logic [4:0] r, logic [9:0] t, logic f,
                                logic c, logic [4:0] g, logic l,
                                int ec, logic e);
        vec_t v;
        v.req = r; v.typ = t; v.full = f; v.cret = c;
        v.eg = g; v.elk = l; v.ec = ec; v.ee = e;
        return v;
    endfunction

    function automatic logic [DS-1:0] mkflit(int p, logic [1:0] t, int n);
        return {4'(p), 4'd2, 8'(n), 22'(n * 16 + p), t};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [4:0] r, logic [9:0] t, logic f, logic c,
                         int n);
        req        = r;
        full_in    = f;
        credit_ret = c;
        for (int p = 0; p < NR; p++)
            req_data[p*DS +: DS] = mkflit(p, t[p*2 +: 2], n);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(5'b0, AS, 1'b0, 1'b0, 0);
        exp_d = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk("rst data_out", data_out, 0);
        chk("rst valid_out", valid_out, 0);
        chk("rst winc", outfifo_winc, 0);
        chk("rst arb_res", arb_res, 0);
        chk("rst credits", credits, 4);
        chk("rst locked", locked, 0);
        chk("rst proto_err", proto_err, 0);
        chk("rst grant", grant, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // round robin over N, E, W
        tv.push_back(mk(5'b10110, AS, 0, 1, 5'b00010, 0, 4, 0));
        tv.push_back(mk(5'b10110, AS, 0, 1, 5'b00100, 0, 4, 0));
        tv.push_back(mk(5'b10110, AS, 0, 1, 5'b10000, 0, 4, 0));
        tv.push_back(mk(5'b10110, AS, 0, 1, 5'b00010, 0, 4, 0));
        // E packet locks out L and S
        tv.push_back(mk(5'b01101, EH, 0, 1, 5'b00100, 0, 4, 0));
        tv.push_back(mk(5'b01101, EB, 0, 1, 5'b00100, 1, 4, 0));
        tv.push_back(mk(5'b01101, ET, 0, 1, 5'b00100, 1, 4, 0));
        tv.push_back(mk(5'b01001, AS, 0, 1, 5'b01000, 0, 4, 0));
        tv.push_back(mk(5'b01001, AS, 0, 1, 5'b00001, 0, 4, 0));
        // credit exhaustion
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00001, 0, 3, 0));
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00001, 0, 2, 0));
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00001, 0, 1, 0));
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00001, 0, 0, 0));
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00000, 0, 0, 0));
        tv.push_back(mk(5'b00001, AS, 0, 1, 5'b00000, 0, 1, 0));
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00001, 0, 0, 0));
        tv.push_back(mk(5'b00001, AS, 0, 0, 5'b00000, 0, 0, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 1, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 2, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 3, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 4, 0));
        // backpressure mid-packet
        tv.push_back(mk(5'b00100, EH, 0, 0, 5'b00100, 0, 3, 0));
        tv.push_back(mk(5'b00101, EB, 1, 0, 5'b00000, 1, 3, 0));
        tv.push_back(mk(5'b00101, EB, 1, 0, 5'b00000, 1, 3, 0));
        tv.push_back(mk(5'b00101, EB, 1, 0, 5'b00000, 1, 3, 0));
        tv.push_back(mk(5'b00101, EB, 0, 0, 5'b00100, 1, 2, 0));
        tv.push_back(mk(5'b00101, ET, 0, 0, 5'b00100, 1, 1, 0));
        tv.push_back(mk(5'b00001, AS, 0, 1, 5'b00001, 0, 1, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 2, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 3, 0));
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 4, 0));
        // faults: credit overflow, SINGLE from lock owner
        tv.push_back(mk(5'b00000, AS, 0, 1, 5'b00000, 0, 4, 1));
        tv.push_back(mk(5'b00100, EH, 0, 1, 5'b00100, 0, 4, 1));
        tv.push_back(mk(5'b00100, AS, 0, 1, 5'b00100, 1, 4, 1));
        tv.push_back(mk(5'b00100, AS, 0, 1, 5'b00100, 0, 4, 1));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].req, tv[i].typ, tv[i].full, tv[i].cret, i + 1);
            #1;
            n_vec++;
            chk($sformatf("v%0d grant", i), grant, tv[i].eg);
            chk($sformatf("v%0d locked", i), locked, tv[i].elk);
            for (int p = 0; p < NR; p++)
                if (tv[i].eg[p]) exp_d = mkflit(p, tv[i].typ[p*2 +: 2], i + 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_out", i), valid_out, |tv[i].eg);
            chk($sformatf("v%0d winc", i), outfifo_winc, |tv[i].eg);
            chk($sformatf("v%0d arb_res", i), arb_res, tv[i].eg);
            chk($sformatf("v%0d data_out", i), data_out, exp_d);
            chk($sformatf("v%0d credits", i), credits, tv[i].ec);
            chk($sformatf("v%0d proto_err", i), proto_err, tv[i].ee);
        end

        // asynchronous reset in the middle of a packet
        @(negedge clk);
        drive(5'b00100, EH, 1'b0, 1'b0, 90);
        @(posedge clk);
        #1;
        n_vec++;
        chk("pre-rst locked", locked, 1);
        chk("pre-rst credits", credits, 3);
        chk("pre-rst valid_out", valid_out, 1);
        chk("pre-rst data_out", data_out, mkflit(2, 2'b01, 90));
        @(negedge clk);
        drive(5'b00100, EB, 1'b0, 1'b0, 91);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("arst data_out", data_out, 0);
        chk("arst valid_out", valid_out, 0);
        chk("arst winc", outfifo_winc, 0);
        chk("arst arb_res", arb_res, 0);
        chk("arst credits", credits, 4);
        chk("arst locked", locked, 0);
        chk("arst proto_err", proto_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b0, AS, 1'b0, 1'b0, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
